// File: rtl/game_io_pkg.sv
// Shared types and default timing constants for the game input sequencer.
// Holds the flap and reset state encodings plus a small width helper.
package game_io_pkg;

    typedef enum logic [1:0] {
        FLAP_IDLE  = 2'd0,
        FLAP_PRESS = 2'd1,
        FLAP_GAP   = 2'd2
    } flap_state_e;

    typedef enum logic {
        RST_HOLD = 1'b0,
        RST_RUN  = 1'b1
    } rst_state_e;

    localparam int DEF_N_SRC        = 3;
    localparam int DEF_DB_CYCLES    = 50000;
    localparam int DEF_PULSE_CYCLES = 200000;
    localparam int DEF_MIN_GAP      = 400000;
    localparam int DEF_RESET_HOLD   = 131071;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/input_debounce.sv
// One fire source: 2-flop synchronizer, saturating debounce counter and a
// single-cycle press pulse on each 0->1 flip of the debounced level.
import game_io_pkg::*;

module input_debounce #(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic sys_reset,
    input  logic raw_i,
    output logic deb_o,
    output logic press_o
);

    localparam int            CW       = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DB_CYCLES);

    logic [1:0]    sync_q;
    logic          deb_q, deb_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (sync_q[1] == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            deb_d   = ~deb_q;
            cnt_d   = '0;
            press_d = ~deb_q;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge sys_reset) begin
        if (!sys_reset) begin
            sync_q  <= '0;
            deb_q   <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], raw_i};
            deb_q   <= deb_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb_o   = deb_q;
    assign press_o = press_q;

endmodule

// File: rtl/game_input_sequencer.sv
// Game reset sequencing plus arbitration of debounced fire sources into one
// rate-limited active-low button pulse stream. FLAP_QUEUE_EN adds a one-deep press queue.
//
// state      | meaning
// RST_HOLD   | core held in reset, counting request-free cycles
// RST_RUN    | core running
// FLAP_IDLE  | waiting for a press event
// FLAP_PRESS | button_n driven low for PULSE_CYCLES
// FLAP_GAP   | button_n high for MIN_GAP before another pulse may start
import game_io_pkg::*;

module game_input_sequencer #(
    parameter int N_SRC        = DEF_N_SRC,
    parameter int DB_CYCLES    = DEF_DB_CYCLES,
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
    parameter int MIN_GAP      = DEF_MIN_GAP,
    parameter int RESET_HOLD   = DEF_RESET_HOLD,
    localparam int GW          = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             clk,
    input  logic             sys_reset,
    input  logic             osd_reset_req,
    input  logic             hw_reset_req,
    input  logic [N_SRC-1:0] fire_src,
    output logic             game_reset_n,
    output logic             button_n,
    output logic [GW-1:0]    grant,
    output logic             busy
);

    localparam int             HCW        = $clog2(RESET_HOLD + 1);
    localparam logic [HCW-1:0] HCNT_LAST  = HCW'(RESET_HOLD - 1);
    localparam logic [HCW-1:0] HCNT_MAX   = HCW'(RESET_HOLD);
    localparam int             FMAX       = max_int(PULSE_CYCLES, MIN_GAP);
    localparam int             FCW        = $clog2(FMAX + 1);
    localparam logic [FCW-1:0] PULSE_LAST = FCW'(PULSE_CYCLES - 1);
    localparam logic [FCW-1:0] GAP_LAST   = FCW'(MIN_GAP - 1);
    localparam logic [FCW-1:0] FCNT_MAX   = FCW'(FMAX);

    logic [N_SRC-1:0] ev, unused_deb;
    logic             ev_any;
    logic [GW-1:0]    ev_idx;

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        input_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk       (clk),
            .sys_reset (sys_reset),
            .raw_i     (fire_src[g]),
            .deb_o     (unused_deb[g]),
            .press_o   (ev[g])
        );
    end

    always_comb begin
        ev_any = |ev;
        ev_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (ev[i]) ev_idx = GW'(i);
        end
    end

    rst_state_e     rst_q, rst_d;
    logic [HCW-1:0] hcnt_q, hcnt_d;
    logic           req;

    assign req = osd_reset_req | hw_reset_req;

    always_comb begin
        rst_d  = rst_q;
        hcnt_d = hcnt_q;
        case (rst_q)
            RST_HOLD: begin
                if (req)                     hcnt_d = '0;
                else if (hcnt_q == HCNT_LAST) rst_d = RST_RUN;
                else if (hcnt_q != HCNT_MAX)  hcnt_d = hcnt_q + 1'b1;
            end
            RST_RUN: begin
                if (req) begin
                    rst_d  = RST_HOLD;
                    hcnt_d = '0;
                end
            end
            default: rst_d = RST_HOLD;
        endcase
    end

    flap_state_e    flap_q, flap_d;
    logic [FCW-1:0] fcnt_q, fcnt_d, fcnt_inc;
    logic [GW-1:0]  grant_q, grant_d;
`ifdef FLAP_QUEUE_EN
    logic           pend_q, pend_d;
    logic [GW-1:0]  pgrant_q, pgrant_d;
`endif

    assign fcnt_inc = (fcnt_q == FCNT_MAX) ? fcnt_q : fcnt_q + 1'b1;

    always_comb begin
        flap_d  = flap_q;
        fcnt_d  = fcnt_q;
        grant_d = grant_q;
`ifdef FLAP_QUEUE_EN
        pend_d   = pend_q;
        pgrant_d = pgrant_q;
`endif
        // Reset hold takes effect on the same edge the reset FSM enters HOLD.
        if (rst_d == RST_HOLD) begin
            flap_d = FLAP_IDLE;
            fcnt_d = '0;
`ifdef FLAP_QUEUE_EN
            pend_d = 1'b0;
`endif
        end else begin
`ifdef FLAP_QUEUE_EN
            if (flap_q != FLAP_IDLE && ev_any && !pend_q) begin
                pend_d   = 1'b1;
                pgrant_d = ev_idx;
            end
`endif
            case (flap_q)
                FLAP_IDLE: begin
                    if (ev_any) begin
                        flap_d  = FLAP_PRESS;
                        fcnt_d  = '0;
                        grant_d = ev_idx;
                    end
                end
                FLAP_PRESS: begin
                    if (fcnt_q == PULSE_LAST) begin
                        flap_d = FLAP_GAP;
                        fcnt_d = '0;
                    end else begin
                        fcnt_d = fcnt_inc;
                    end
                end
                FLAP_GAP: begin
                    if (fcnt_q == GAP_LAST) begin
                        flap_d = FLAP_IDLE;
                        fcnt_d = '0;
`ifdef FLAP_QUEUE_EN
                        if (pend_q) begin
                            flap_d  = FLAP_PRESS;
                            grant_d = pgrant_q;
                            pend_d  = 1'b0;
                        end else if (ev_any) begin
                            flap_d  = FLAP_PRESS;
                            grant_d = ev_idx;
                            pend_d  = 1'b0;
                        end
`endif
                    end else begin
                        fcnt_d = fcnt_inc;
                    end
                end
                default: flap_d = FLAP_IDLE;
            endcase
        end
    end

    logic game_reset_n_q, button_n_q, busy_q;

    always_ff @(posedge clk or negedge sys_reset) begin
        if (!sys_reset) begin
            rst_q          <= RST_HOLD;
            hcnt_q         <= '0;
            flap_q         <= FLAP_IDLE;
            fcnt_q         <= '0;
            grant_q        <= '0;
            game_reset_n_q <= 1'b0;
            button_n_q     <= 1'b1;
            busy_q         <= 1'b0;
`ifdef FLAP_QUEUE_EN
            pend_q         <= 1'b0;
            pgrant_q       <= '0;
`endif
        end else begin
            rst_q          <= rst_d;
            hcnt_q         <= hcnt_d;
            flap_q         <= flap_d;
            fcnt_q         <= fcnt_d;
            grant_q        <= grant_d;
            game_reset_n_q <= (rst_d == RST_RUN);
            button_n_q     <= (flap_d != FLAP_PRESS);
            busy_q         <= (flap_d != FLAP_IDLE);
`ifdef FLAP_QUEUE_EN
            pend_q         <= pend_d;
            pgrant_q       <= pgrant_d;
`endif
        end
    end

    assign game_reset_n = game_reset_n_q;
    assign button_n     = button_n_q;
    assign grant        = grant_q;
    assign busy         = busy_q;

endmodule
